// File: rtl/multichan_slowfir_pkg.sv
// Shared definitions for the slow multi-channel FIR family.
//   fir_state_t : controller state encoding
//   acc_width   : accumulator width for a given sample/tap width and tap count
//   round_sat   : round-half-up arithmetic right shift followed by signed clamp
package multichan_slowfir_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_MAC   = 2'd2,
        ST_FLUSH = 2'd3
    } fir_state_t;

    localparam int RS_W = 128;
    typedef logic signed [RS_W-1:0] rs_wide_t;

    function automatic int acc_width(input int iw, input int tw, input int lgntaps);
        return iw + tw + lgntaps;
    endfunction

    // Works on a wide signed value so any filter in the family can share it;
    // callers truncate the result to their output width. When ow is wide
    // enough the clamp never fires and the result is a plain sign extension.
    function automatic rs_wide_t round_sat(input rs_wide_t v, input int shift, input int ow);
        rs_wide_t r;
        rs_wide_t hi;
        rs_wide_t lo;
        r = v;
        if (shift > 0)
            r = r + (rs_wide_t'(1) <<< (shift - 1));
        r  = r >>> shift;
        hi = (rs_wide_t'(1) <<< (ow - 1)) - rs_wide_t'(1);
        lo = -(rs_wide_t'(1) <<< (ow - 1));
        if (r > hi)
            r = hi;
        else if (r < lo)
            r = lo;
        return r;
    endfunction

endpackage

// File: rtl/multichan_slowfir_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Used for the per-channel sample delay lines and for the tap memory.
//   clk      : clock
//   wr_en    : write strobe; wr_addr/wr_data written on the clock edge
//   rd_addr  : read address; rd_data valid one cycle later (old data on
//              a same-cycle write to the same address)
module fir_sample_ram #(
    parameter int    DW        = 16,
    parameter int    ABITS     = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [ABITS-1:0] wr_addr,
    input  logic [DW-1:0]    wr_data,
    input  logic [ABITS-1:0] rd_addr,
    output logic [DW-1:0]    rd_data
);
    logic [DW-1:0] mem [2**ABITS];
    logic [DW-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_addr];
    end

    assign rd_data = rd_q;
endmodule

// File: rtl/multichan_slowfir.sv
// Time-multiplexed multi-channel FIR with a single shared multiplier.
// Each accepted sample runs NTAPS multiply-accumulates against that
// channel's delay line, then rounds/saturates and strobes the result.
//   i_clk, i_reset   : clock, synchronous active-high reset
//   i_tap_wr, i_tap  : tap load strobe/value (sequential write index)
//   i_ce, i_chan, i_sample : sample strobe, channel, signed sample
//   o_busy           : clearing or computing; i_ce accepted only when low
//   o_ce, o_chan, o_result : result strobe, channel, signed result (held)
//   o_overrun        : sticky flag for i_ce arriving while busy
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | zero the sample RAM, one word per cycle
// ST_IDLE  | waiting for a sample; tap writes accepted
// ST_MAC   | issue RAM reads for taps k = 0..NTAPS-1
// ST_FLUSH | drain read/multiply/accumulate pipe, register the result
module multichan_slowfir
    import multichan_slowfir_pkg::*;
#(
    parameter int LGNTAPS    = 7,
    parameter int LGNCH      = 1,
    parameter int IW         = 16,
    parameter int TW         = 16,
    parameter int OW         = 40,
    parameter int SHIFT      = 0,
    parameter int FIXED_TAPS = 0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tap_wr,
    input  logic [TW-1:0]    i_tap,
    input  logic             i_ce,
    input  logic [LGNCH-1:0] i_chan,
    input  logic [IW-1:0]    i_sample,
    output logic             o_busy,
    output logic             o_ce,
    output logic [LGNCH-1:0] o_chan,
    output logic [OW-1:0]    o_result,
    output logic             o_overrun
);
    localparam int NCH = 2**LGNCH;
    localparam int PW  = IW + TW;
    localparam int AW  = acc_width(IW, TW, LGNTAPS);
    localparam int SAW = LGNCH + LGNTAPS;

    fir_state_t state_q, state_d;

    logic [LGNTAPS-1:0] k_q, k_d;
    logic [SAW-1:0]     clr_q, clr_d;
    logic [LGNTAPS-1:0] wptr_q [NCH];
    logic [LGNTAPS-1:0] wptr_d [NCH];
    logic [LGNTAPS-1:0] twidx_q, twidx_d;
    logic [LGNCH-1:0]   chan_q, chan_d;

    logic rd_vld_q, rd_vld_d, rd_first_q, rd_first_d, rd_last_q, rd_last_d;
    logic prod_vld_q, prod_vld_d, prod_first_q, prod_first_d, prod_last_q, prod_last_d;
    logic [PW-1:0] prod_q, prod_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          acc_last_q, acc_last_d;

    logic             ce_q, ce_d;
    logic [LGNCH-1:0] ochan_q, ochan_d;
    logic [OW-1:0]    result_q, result_d;
    logic             ovr_q, ovr_d;

    logic           accept;
    logic           tap_we;
    logic           smp_we;
    logic [SAW-1:0] smp_waddr;
    logic [IW-1:0]  smp_wdata;
    logic [SAW-1:0] smp_raddr;
    logic [IW-1:0]  smp_rd;
    logic [TW-1:0]  tap_rd;
    logic [PW-1:0]  smp_ext;
    logic [PW-1:0]  tap_ext;
    logic [AW-1:0]  prod_ext;

    assign accept = (state_q == ST_IDLE) && i_ce;
    assign tap_we = (FIXED_TAPS == 0) && (state_q == ST_IDLE) && i_tap_wr;

    // The sweep owns the write port during CLEAR; otherwise only an accepted
    // sample writes, at the slot its channel pointer currently names.
    always_comb begin
        smp_we    = 1'b0;
        smp_waddr = {i_chan, wptr_q[i_chan]};
        smp_wdata = i_sample;
        if (state_q == ST_CLEAR) begin
            smp_we    = 1'b1;
            smp_waddr = clr_q;
            smp_wdata = '0;
        end else if (accept) begin
            smp_we = 1'b1;
        end
    end

    // Walk backwards from the newest sample so tap k meets x[n-k].
    assign smp_raddr = {chan_q, wptr_q[chan_q] - k_q};

    fir_sample_ram #(.DW(IW), .ABITS(SAW)) u_smp_ram (
        .clk     (i_clk),
        .wr_en   (smp_we),
        .wr_addr (smp_waddr),
        .wr_data (smp_wdata),
        .rd_addr (smp_raddr),
        .rd_data (smp_rd)
    );

    fir_sample_ram #(.DW(TW), .ABITS(LGNTAPS)) u_tap_ram (
        .clk     (i_clk),
        .wr_en   (tap_we),
        .wr_addr (twidx_q),
        .wr_data (i_tap),
        .rd_addr (k_q),
        .rd_data (tap_rd)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_reset)
            state_q <= ST_CLEAR;
        else
            state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_CLEAR: if (clr_q == '1)   state_d = ST_IDLE;
            ST_IDLE:  if (i_ce)          state_d = ST_MAC;
            ST_MAC:   if (k_q == '1)     state_d = ST_FLUSH;
            ST_FLUSH: if (acc_last_q)    state_d = ST_IDLE;
            default:                     state_d = ST_CLEAR;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        o_busy = (state_q != ST_IDLE);
    end

    // ---------------- datapath ----------------
    assign smp_ext  = {{TW{smp_rd[IW-1]}}, smp_rd};
    assign tap_ext  = {{IW{tap_rd[TW-1]}}, tap_rd};
    assign prod_ext = {{LGNTAPS{prod_q[PW-1]}}, prod_q};

    always_comb begin
        k_d     = k_q;
        clr_d   = clr_q;
        wptr_d  = wptr_q;
        twidx_d = twidx_q;
        chan_d  = chan_q;

        if (state_q == ST_CLEAR)
            clr_d = clr_q + 1'b1;
        if (accept) begin
            chan_d = i_chan;
            k_d    = '0;
        end
        if (state_q == ST_MAC)
            k_d = k_q + 1'b1;
        if (tap_we)
            twidx_d = twidx_q + 1'b1;

        // Position tags travel alongside the data through read and multiply.
        rd_vld_d   = (state_q == ST_MAC);
        rd_first_d = (state_q == ST_MAC) && (k_q == '0);
        rd_last_d  = (state_q == ST_MAC) && (k_q == '1);

        prod_vld_d   = rd_vld_q;
        prod_first_d = rd_first_q;
        prod_last_d  = rd_last_q;
        prod_d       = smp_ext * tap_ext;

        acc_d = acc_q;
        if (prod_vld_q)
            acc_d = prod_first_q ? prod_ext : (acc_q + prod_ext);
        acc_last_d = prod_vld_q && prod_last_q;

        ce_d     = acc_last_q;
        ochan_d  = ochan_q;
        result_d = result_q;
        if (acc_last_q) begin
            result_d       = OW'(round_sat(rs_wide_t'($signed(acc_q)), SHIFT, OW));
            ochan_d        = chan_q;
            wptr_d[chan_q] = wptr_q[chan_q] + 1'b1;
        end

        ovr_d = ovr_q | (i_ce && (state_q != ST_IDLE));
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            k_q          <= '0;
            clr_q        <= '0;
            wptr_q       <= '{default: '0};
            twidx_q      <= '0;
            chan_q       <= '0;
            rd_vld_q     <= 1'b0;
            rd_first_q   <= 1'b0;
            rd_last_q    <= 1'b0;
            prod_vld_q   <= 1'b0;
            prod_first_q <= 1'b0;
            prod_last_q  <= 1'b0;
            prod_q       <= '0;
            acc_q        <= '0;
            acc_last_q   <= 1'b0;
            ce_q         <= 1'b0;
            ochan_q      <= '0;
            result_q     <= '0;
            ovr_q        <= 1'b0;
        end else begin
            k_q          <= k_d;
            clr_q        <= clr_d;
            wptr_q       <= wptr_d;
            twidx_q      <= twidx_d;
            chan_q       <= chan_d;
            rd_vld_q     <= rd_vld_d;
            rd_first_q   <= rd_first_d;
            rd_last_q    <= rd_last_d;
            prod_vld_q   <= prod_vld_d;
            prod_first_q <= prod_first_d;
            prod_last_q  <= prod_last_d;
            prod_q       <= prod_d;
            acc_q        <= acc_d;
            acc_last_q   <= acc_last_d;
            ce_q         <= ce_d;
            ochan_q      <= ochan_d;
            result_q     <= result_d;
            ovr_q        <= ovr_d;
        end
    end

    assign o_ce      = ce_q;
    assign o_chan    = ochan_q;
    assign o_result  = result_q;
    assign o_overrun = ovr_q;
endmodule

// File: tb/tb_multichan_slowfir.sv
// Bench for multichan_slowfir: two instances share all inputs, one wide
// (OW=20, SHIFT=0) and one narrow (OW=12, SHIFT=4), both checked every
// cycle against a sum-of-products reference of the filter.
module tb_multichan_slowfir;
    localparam int LGNTAPS = 3;
    localparam int LGNCH   = 1;
    localparam int IW      = 8;
    localparam int TW      = 8;
    localparam int NTAPS   = 8;
    localparam int NCH     = 2;
    localparam int LAT     = NTAPS + 3;
    localparam int CLR_LEN = NCH * NTAPS;
    localparam int OW_A = 20, SH_A = 0;
    localparam int OW_B = 12, SH_B = 4;

    logic clk = 1'b0;
    logic rst, tap_wr, ce;
    logic [TW-1:0]    tap;
    logic [LGNCH-1:0] chan;
    logic [IW-1:0]    sample;

    logic busy_a, ce_a, ovr_a, busy_b, ce_b, ovr_b;
    logic [LGNCH-1:0] chan_a, chan_b;
    logic [OW_A-1:0]  res_a;
    logic [OW_B-1:0]  res_b;

    always #5 clk = ~clk;

    multichan_slowfir #(.LGNTAPS(LGNTAPS), .LGNCH(LGNCH), .IW(IW), .TW(TW),
                        .OW(OW_A), .SHIFT(SH_A), .FIXED_TAPS(0)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_tap_wr(tap_wr), .i_tap(tap),
        .i_ce(ce), .i_chan(chan), .i_sample(sample),
        .o_busy(busy_a), .o_ce(ce_a), .o_chan(chan_a), .o_result(res_a),
        .o_overrun(ovr_a));

    multichan_slowfir #(.LGNTAPS(LGNTAPS), .LGNCH(LGNCH), .IW(IW), .TW(TW),
                        .OW(OW_B), .SHIFT(SH_B), .FIXED_TAPS(0)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_tap_wr(tap_wr), .i_tap(tap),
        .i_ce(ce), .i_chan(chan), .i_sample(sample),
        .o_busy(busy_b), .o_ce(ce_b), .o_chan(chan_b), .o_result(res_b),
        .o_overrun(ovr_b));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // reference state
    bit     started = 1'b0;
    int     free_at = 0;
    int     exp_ce_at = -1;
    longint pend_a, pend_b, held_a, held_b;
    int     pend_chan, held_chan;
    bit     m_ovr;
    int     twidx;
    int     taps [NTAPS];
    int     hist [NCH][NTAPS];

    task automatic chk(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint shape(input longint y, input int sh, input int ow);
        longint v, hi, lo;
        v = y;
        if (sh > 0) v = v + (longint'(1) << (sh - 1));
        v  = v >>> sh;
        hi = (longint'(1) << (ow - 1)) - 1;
        lo = -(longint'(1) << (ow - 1));
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        return v;
    endfunction

    task automatic model_edge(input bit r, input bit c, input int ch, input int x,
                              input bit tw, input int tv);
        bit     idle;
        longint y;
        if (r) begin
            started   = 1'b1;
            free_at   = cyc + CLR_LEN;
            exp_ce_at = -1;
            held_a = 0; held_b = 0; held_chan = 0;
            m_ovr  = 1'b0;
            twidx  = 0;
            for (int i = 0; i < NCH; i++)
                for (int k = 0; k < NTAPS; k++) hist[i][k] = 0;
        end else begin
            idle = (cyc - 1 >= free_at);
            if (cyc == exp_ce_at) begin
                held_a = pend_a; held_b = pend_b; held_chan = pend_chan;
            end
            if (tw && idle) begin
                taps[twidx] = tv;
                twidx = (twidx + 1) % NTAPS;
            end
            if (c) begin
                if (idle) begin
                    for (int k = NTAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
                    hist[ch][0] = x;
                    y = 0;
                    for (int k = 0; k < NTAPS; k++)
                        y += longint'(taps[k]) * longint'(hist[ch][k]);
                    pend_a    = shape(y, SH_A, OW_A);
                    pend_b    = shape(y, SH_B, OW_B);
                    pend_chan = ch;
                    exp_ce_at = cyc + LAT;
                    free_at   = cyc + LAT;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
    endtask

    task automatic tick(input bit r, input bit c, input int ch, input int x,
                        input bit tw, input int tv);
        rst    = r;
        ce     = c;
        chan   = ch[LGNCH-1:0];
        sample = x[IW-1:0];
        tap_wr = tw;
        tap    = tv[TW-1:0];
        @(posedge clk);
        cyc++;
        model_edge(r, c, ch, x, tw, tv);
        #1;
        if (started) begin
            chk("busy_a", busy_a, cyc < free_at);
            chk("busy_b", busy_b, cyc < free_at);
            chk("o_ce_a", ce_a, cyc == exp_ce_at);
            chk("o_ce_b", ce_b, cyc == exp_ce_at);
            chk("ovr_a", ovr_a, m_ovr);
            chk("ovr_b", ovr_b, m_ovr);
            chk("res_a", longint'($signed(res_a)), held_a);
            chk("res_b", longint'($signed(res_b)), held_b);
            chk("chan_a", chan_a, held_chan);
            chk("chan_b", chan_b, held_chan);
        end
    endtask

    task automatic idle_n(input int n);
        repeat (n) tick(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (cyc < free_at && guard < 200) begin
            tick(0, 0, 0, 0, 0, 0);
            guard++;
        end
        if (guard >= 200) chk("idle_timeout", cyc, free_at);
    endtask

    task automatic send(input int ch, input int x);
        wait_idle();
        tick(0, 1, ch, x, 0, 0);
    endtask

    task automatic wtap(input int v);
        wait_idle();
        tick(0, 0, 0, 0, 1, v);
    endtask

    task automatic reset_and_clear();
        int n;
        tick(1, 0, 0, 0, 0, 0);
        n = 0;
        while (busy_a && n < 100) begin
            n++;
            tick(0, 0, 0, 0, 0, 0);
        end
        chk("clear_len", n, CLR_LEN);
    endtask

    task automatic random_phase(input int iters);
        int r;
        for (int i = 0; i < iters; i++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)
                wtap(int'($urandom_range(0, 255)) - 128);
            else if (r == 1)
                tick(0, 1, int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 255)) - 128,
                     1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128);
            else if (r == 2)
                idle_n(int'($urandom_range(1, 12)));
            else
                send(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, 255)) - 128);
        end
    endtask

    initial begin
        rst = 1'b0; tap_wr = 1'b0; ce = 1'b0;
        tap = '0; chan = '0; sample = '0;
        for (int k = 0; k < NTAPS; k++) taps[k] = 0;
        @(negedge clk);

        reset_and_clear();
        chk("rst_res", longint'($signed(res_a)), 0);
        idle_n(3);

        // taps 1..8 then a unit impulse on channel 0
        for (int v = 1; v <= NTAPS; v++) wtap(v);
        for (int i = 0; i < NTAPS; i++) begin
            send(0, (i == 0) ? 1 : 0);
            wait_idle();
            chk("impulse", longint'($signed(res_a)), i + 1);
        end

        // interleaved channels: ch0 impulse of 10, ch1 constant 1
        for (int i = 0; i < NTAPS; i++) begin
            send(0, (i == 0) ? 10 : 0);
            wait_idle();
            chk("ch0_imp10", longint'($signed(res_a)), 10 * (i + 1));
            send(1, 1);
            wait_idle();
            chk("ch1_runsum", longint'($signed(res_a)), (i + 1) * (i + 2) / 2);
        end

        // overrun on cycle 5, busy tap write dropped, next idle write at index 0
        send(0, 5);
        idle_n(4);
        tick(0, 1, 1, 77, 0, 0);
        tick(0, 0, 0, 0, 1, 99);
        wait_idle();
        chk("ovr_set", ovr_a, 1);
        chk("ovr_result", longint'($signed(res_a)), 5);
        wtap(3);
        send(1, 1);
        wait_idle();
        chk("tap_idx", longint'($signed(res_a)), 3 + 2 + 3 + 4 + 5 + 6 + 7 + 8);

        // reset in the middle of a computation
        send(1, 7);
        idle_n(3);
        reset_and_clear();
        chk("ovr_clr", ovr_a, 0);
        idle_n(LAT);

        random_phase(150);

        // saturation: all taps and samples at the negative limit
        wait_idle();
        reset_and_clear();
        for (int k = 0; k < NTAPS; k++) wtap(-128);
        for (int i = 0; i < NTAPS; i++) send(0, -128);
        wait_idle();
        chk("sat_a", longint'($signed(res_a)), 131072);
        chk("sat_b", longint'($signed(res_b)), 2047);
        idle_n(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
